program_loader: RTL and testbench

- Boot-time loader directly upstream of the pipelined RISC-V cpu.
- Accepts a valid/ready stream of 64-bit words and writes the program into instruction memory through the cpu's addr_ext/wen_ext/wdata_ext port.
- Writes the initial data image into data memory through the cpu's addr_ext_2/wen_ext_2/wdata_ext_2 port.
- Asserts the cpu enable once the load completes, and withdraws it on halt.

---
 rtl/program_loader.sv | 187 ++++++++++++++++++
 tb/tb_program_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: takes a header plus payload words from a stream, writes instruction
// and data memories through the cpu external ports, then enables the cpu.
module program_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        halt,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [63:0] imem_addr_ext,
  output logic        imem_wen_ext,
  output logic [31:0] imem_wdata_ext,
  output logic [63:0] dmem_addr_ext,
  output logic        dmem_wen_ext,
  output logic [63:0] dmem_wdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [31:0] words_loaded,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_IMEM = 3'd2;
  localparam logic [2:0] S_DMEM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);

  logic [2:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        en_q, en_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ic_q, ic_d;
  logic [15:0] dc_q, dc_d;
  logic [31:0] wl_q, wl_d;
  logic        iw_q, iw_d;
  logic [63:0] ia_q, ia_d;
  logic [31:0] id_q, id_d;
  logic        dw_q, dw_d;
  logic [63:0] da_q, da_d;
  logic [63:0] dd_q, dd_d;
  logic        accept;
  logic [15:0] hdr_ic, hdr_dc;

  // Handshake: a word transfers on a rising edge where s_valid and s_ready are both
  // high; s_ready is registered, so halt in the same cycle vetoes the transfer here.
  assign accept = s_valid && ready_q && !halt;
  assign hdr_ic = s_data[15:0];
  assign hdr_dc = s_data[31:16];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ic_d    = ic_q;
    dc_d    = dc_q;
    wl_d    = wl_q;
    iw_d    = 1'b0;
    ia_d    = ia_q;
    id_d    = id_q;
    dw_d    = 1'b0;
    da_d    = da_q;
    dd_d    = dd_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
          ic_d    = '0;
          dc_d    = '0;
          wl_d    = '0;
        end
      end
      S_HDR: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (accept) begin
          ic_d = hdr_ic;
          dc_d = hdr_dc;
          if ({1'b0, hdr_ic} > IMEM_LIM || {1'b0, hdr_dc} > DMEM_LIM) state_d = S_ERR;
          else if (hdr_ic != '0) state_d = S_IMEM;
          else if (hdr_dc != '0) state_d = S_DMEM;
          else state_d = S_RUN;
        end
      end
      S_IMEM: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (accept) begin
          iw_d = 1'b1;
          ia_d = {46'd0, cnt_q, 2'b00};
          id_d = s_data[31:0];
          wl_d = wl_q + 32'd1;
          if (cnt_q + 16'd1 == ic_q) begin
            cnt_d   = '0;
            state_d = (dc_q != '0) ? S_DMEM : S_RUN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DMEM: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (accept) begin
          dw_d = 1'b1;
          da_d = {45'd0, cnt_q, 3'b000};
          dd_d = s_data;
          wl_d = wl_q + 32'd1;
          if (cnt_q + 16'd1 == dc_q) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_RUN: begin
        if (halt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_HDR) || (state_d == S_IMEM) || (state_d == S_DMEM);
  assign err_d   = (state_d == S_ERR);
  // Enable lags RUN entry by one edge so the last memory strobe always comes first.
  assign en_d    = (state_q == S_RUN) && !halt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      ic_q    <= '0;
      dc_q    <= '0;
      wl_q    <= '0;
      iw_q    <= 1'b0;
      ia_q    <= '0;
      id_q    <= '0;
      dw_q    <= 1'b0;
      da_q    <= '0;
      dd_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      ic_q    <= ic_d;
      dc_q    <= dc_d;
      wl_q    <= wl_d;
      iw_q    <= iw_d;
      ia_q    <= ia_d;
      id_q    <= id_d;
      dw_q    <= dw_d;
      da_q    <= da_d;
      dd_q    <= dd_d;
    end
  end

  assign s_ready        = ready_q;
  assign busy           = ready_q;
  assign err            = err_q;
  assign cpu_enable     = en_q;
  assign words_loaded   = wl_q;
  assign imem_wen_ext   = iw_q;
  assign imem_addr_ext  = ia_q;
  assign imem_wdata_ext = id_q;
  assign dmem_wen_ext   = dw_q;
  assign dmem_addr_ext  = da_q;
  assign dmem_wdata_ext = dd_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: control vectors from a table, scripted load
// sessions, and a strobe scoreboard checking address, data and 1-cycle latency.
module tb_program_loader;

  logic        clk;
  logic        arst;
  logic        start;
  logic        halt;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] imem_addr_ext;
  logic        imem_wen_ext;
  logic [31:0] imem_wdata_ext;
  logic [63:0] dmem_addr_ext;
  logic        dmem_wen_ext;
  logic [63:0] dmem_wdata_ext;
  logic        cpu_enable;
  logic        busy;
  logic        err;
  logic [31:0] words_loaded;
  logic [2:0]  dbg_state;

  program_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
    .clk(clk), .arst(arst), .start(start), .halt(halt),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .imem_addr_ext(imem_addr_ext), .imem_wen_ext(imem_wen_ext), .imem_wdata_ext(imem_wdata_ext),
    .dmem_addr_ext(dmem_addr_ext), .dmem_wen_ext(dmem_wen_ext), .dmem_wdata_ext(dmem_wdata_ext),
    .cpu_enable(cpu_enable), .busy(busy), .err(err), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_HDR = 3'd1, S_IMEM = 3'd2;
  localparam logic [2:0] S_RUN = 3'd4, S_ERR = 3'd5;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int i_idx = 0;
  int d_idx = 0;

  // Scoreboard entries: {strobe cycle, address, data}
  logic [127:0] exp_i_q[$];
  logic [159:0] exp_d_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_imem_addr"}, imem_addr_ext, 64'd0);
    chk({tag, "_imem_wen"}, 64'(imem_wen_ext), 64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata_ext), 64'd0);
    chk({tag, "_dmem_addr"}, dmem_addr_ext, 64'd0);
    chk({tag, "_dmem_wen"}, 64'(dmem_wen_ext), 64'd0);
    chk({tag, "_dmem_wdata"}, dmem_wdata_ext, 64'd0);
    chk({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  always @(negedge clk) begin
    logic [127:0] ei;
    logic [159:0] ed;
    if (imem_wen_ext === 1'b1) begin
      if (exp_i_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL imem_strobe: unexpected write addr=%h data=%h cycle %0d", imem_addr_ext, imem_wdata_ext, cyc);
      end else begin
        ei = exp_i_q.pop_front();
        chk("imem_strobe_cycle", 64'(cyc), 64'(ei[127:96]));
        chk("imem_addr", imem_addr_ext, ei[95:32]);
        chk("imem_wdata", 64'(imem_wdata_ext), 64'(ei[31:0]));
      end
    end
    if (dmem_wen_ext === 1'b1) begin
      if (exp_d_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dmem_strobe: unexpected write addr=%h data=%h cycle %0d", dmem_addr_ext, dmem_wdata_ext, cyc);
      end else begin
        ed = exp_d_q.pop_front();
        chk("dmem_strobe_cycle", 64'(cyc), 64'(ed[159:128]));
        chk("dmem_addr", dmem_addr_ext, ed[127:64]);
        chk("dmem_wdata", dmem_wdata_ext, ed[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  // kind: 0 header, 1 imem payload, 2 dmem payload. Returns at the negedge after the accept edge.
  task automatic send(input logic [63:0] d, input int kind, input bit rand_valid);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    s_data = d;
    while (!done && n < 200) begin
      s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_valid && s_ready && !halt) begin
        done = 1'b1;
        if (kind == 1) begin
          exp_i_q.push_back({32'(cyc + 1), 64'(i_idx * 4), d[31:0]});
          i_idx++;
        end else if (kind == 2) begin
          exp_d_q.push_back({32'(cyc + 1), 64'(d_idx * 8), d});
          d_idx++;
        end
      end
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  // ---------------- control vector table ----------------
  typedef struct {
    logic        start;
    logic        halt;
    logic        valid;
    logic [63:0] data;
    logic        ready;
    logic        busy;
    logic        err;
    logic        en;
    logic [2:0]  state;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic hl, input logic vl, input logic [63:0] d,
                              input logic rd, input logic er, input logic en, input logic [2:0] s);
    vec_t v;
    v.start = st; v.halt = hl; v.valid = vl; v.data = d;
    v.ready = rd; v.busy = rd; v.err = er; v.en = en; v.state = s;
    return v;
  endfunction

  vec_t vecs[15];

  logic [31:0] prog[3];

  initial begin
    // inputs -> state observed one edge later
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 1'b0, S_HDR);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 64'h0,         1'b0, 1'b0, 1'b0, S_RUN);  // ic=0, dc=0
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 1'b1, S_RUN);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 1'b0, 1'b1, S_RUN);  // start ignored
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 64'h0,         1'b0, 1'b0, 1'b0, S_IDLE);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 1'b0, S_HDR);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 64'h201,       1'b0, 1'b1, 1'b0, S_ERR);  // ic=513
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 64'h1,         1'b0, 1'b1, 1'b0, S_ERR);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 1'b0, S_HDR);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 64'h0401_0000, 1'b0, 1'b1, 1'b0, S_ERR);  // dc=1025
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 1'b0, S_HDR);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 64'h0,         1'b0, 1'b0, 1'b0, S_IDLE); // halt beats header
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 1'b0, 1'b0, S_HDR);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 64'h200,       1'b1, 1'b0, 1'b0, S_IMEM); // ic=512 legal
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 64'h0,         1'b0, 1'b0, 1'b0, S_IDLE);

    prog[0] = 32'h00A00093;
    prog[1] = 32'h00100113;
    prog[2] = 32'h002081B3;

    arst = 1'b1;
    start = 1'b0;
    halt = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // control table
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start;
      halt = vecs[i].halt;
      s_valid = vecs[i].valid;
      s_data = vecs[i].data;
      @(negedge clk);
      start = 1'b0;
      halt = 1'b0;
      s_valid = 1'b0;
      chk($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(vecs[i].state));
      chk($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(vecs[i].ready));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
      chk($sformatf("vec%0d_cpu_enable", i), 64'(cpu_enable), 64'(vecs[i].en));
      chk($sformatf("vec%0d_words_loaded", i), 64'(words_loaded), 64'd0);
    end

    // full load: 3 imem words then 2 dmem words
    do_start();
    i_idx = 0;
    d_idx = 0;
    send(64'h0000_0000_0002_0003, 0, 1'b0);
    for (int i = 0; i < 3; i++) send({32'h0, prog[i]}, 1, 1'b0);
    send(64'h11, 2, 1'b0);
    send(64'h22, 2, 1'b0);
    chk("full_last_strobe_enable", 64'(cpu_enable), 64'd0);
    chk("full_words_loaded", 64'(words_loaded), 64'd5);
    chk("full_state_run", 64'(dbg_state), 64'(S_RUN));
    @(negedge clk);
    chk("full_enable_rise", 64'(cpu_enable), 64'd1);
    chk("full_ready_low", 64'(s_ready), 64'd0);
    do_halt();
    chk("halt_run_enable", 64'(cpu_enable), 64'd0);
    chk("halt_run_state", 64'(dbg_state), 64'(S_IDLE));

    // upper header bits ignored: ic=3, dc=0 straight to RUN
    do_start();
    chk("restart_words_cleared", 64'(words_loaded), 64'd0);
    i_idx = 0;
    send(64'h0000_0002_0000_0003, 0, 1'b0);
    for (int i = 0; i < 3; i++) send({32'h0, prog[i]}, 1, 1'b0);
    chk("hdr_upper_state_run", 64'(dbg_state), 64'(S_RUN));
    @(negedge clk);
    chk("hdr_upper_enable", 64'(cpu_enable), 64'd1);
    do_halt();

    // ic = IMEM_DEPTH: full depth, last address 4*511
    do_start();
    i_idx = 0;
    send(64'h200, 0, 1'b0);
    for (int i = 0; i < 512; i++) send(64'(32'hC000_0000 + 32'(i)), 1, 1'b0);
    chk("depth_words_loaded", 64'(words_loaded), 64'd512);
    chk("depth_last_addr", imem_addr_ext, 64'd2044);
    chk("depth_state_run", 64'(dbg_state), 64'(S_RUN));
    do_halt();

    // random s_valid stalls over 4 imem words
    do_start();
    i_idx = 0;
    send(64'h4, 0, 1'b0);
    for (int i = 0; i < 4; i++) send(64'hBEEF_0000 + 64'(i), 1, 1'b1);
    chk("stall_words_loaded", 64'(words_loaded), 64'd4);
    chk("stall_state_run", 64'(dbg_state), 64'(S_RUN));
    do_halt();

    // halt after 2 of 4 imem words; the word offered with halt is dropped
    do_start();
    i_idx = 0;
    send(64'h4, 0, 1'b0);
    send(64'h1111, 1, 1'b0);
    send(64'h2222, 1, 1'b0);
    halt = 1'b1;
    s_valid = 1'b1;
    s_data = 64'h3333;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_imem_state", 64'(dbg_state), 64'(S_IDLE));
    chk("halt_imem_ready", 64'(s_ready), 64'd0);
    chk("halt_imem_enable", 64'(cpu_enable), 64'd0);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("halt_imem_words_loaded", 64'(words_loaded), 64'd2);

    // asynchronous reset while in DMEM
    do_start();
    d_idx = 0;
    send(64'h0000_0000_0003_0000, 0, 1'b0);
    send(64'hAAAA_5555, 2, 1'b0);
    s_valid = 1'b1;
    s_data = 64'hBBBB;
    #2;
    arst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    arst = 1'b0;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk_all_zero("post_reset");

    chk("imem_queue_drained", 64'(exp_i_q.size()), 64'd0);
    chk("dmem_queue_drained", 64'(exp_d_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
